// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control sequencer: FSM states, opcode
// constants, decoded-control and strobe bundles.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_DONE
  } state_t;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SHIFT   = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_BRANCH  = 3'd3;
  localparam logic [2:0] OP_LOAD    = 3'd4;
  localparam logic [2:0] OP_STORE   = 3'd5;
  localparam logic [2:0] OP_LOADREG = 3'd6;
  localparam logic [2:0] OP_CONCAT  = 3'd7;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       is_branch;
    logic       is_shift;
    logic       is_add;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       wb_en;
    logic       legal;
  } ctrl_t;

  typedef struct packed {
    logic ir_write;
    logic pc_write;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic ack;
    logic illegal_op;
    logic mem_err;
  } strobe_t;

  // Reset / illegal-opcode control word: ALU op parked at all-ones, no side effects.
  localparam ctrl_t CTRL_NOP = '{alu_op: 3'b111, default: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the IR opcode field onto a ctrl_t word.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] instr_i,
  output ctrl_t          ctrl_o
);

  logic [2:0] code;

  always_comb begin
    code          = instr_i[2:0];
    ctrl_o        = '0;
    ctrl_o.alu_op = code;
    ctrl_o.legal  = (32'(instr_i) < 32'd8);
    case (code)
      OP_ADD:     begin ctrl_o.is_add = 1'b1; ctrl_o.wb_en = 1'b1; end
      OP_SHIFT:   begin ctrl_o.is_shift = 1'b1; ctrl_o.wb_en = 1'b1; end
      OP_XOR:     ctrl_o.wb_en = 1'b1;
      OP_BRANCH:  ctrl_o.is_branch = 1'b1;
      OP_LOAD:    begin ctrl_o.mem_rd = 1'b1; ctrl_o.mem_to_reg = 1'b1; ctrl_o.wb_en = 1'b1; end
      OP_STORE:   ctrl_o.mem_wr = 1'b1;
      OP_LOADREG: ctrl_o.wb_en = 1'b1;
      OP_CONCAT:  ctrl_o.wb_en = 1'b1;
      default:    ;
    endcase
    if (!ctrl_o.legal) ctrl_o = CTRL_NOP;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with registered strobes.
// Optional CTRL_PERF_EN adds saturating retired-instruction and cycle counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW    = 3,
  parameter int ALUOPW = 3,
  parameter int MEM_TO = 15,
  parameter int CNTW   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic [OPW-1:0]    instr,
  input  logic              Halt,
  input  logic              BrCond,
  input  logic              mem_ready,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              Branch,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              isBranch,
  output logic              isShift,
  output logic              isAdd,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              Ack,
  output logic              IllegalOp,
  output logic              MemErr,
`ifdef CTRL_PERF_EN
  output logic [CNTW-1:0]   RetiredCnt,
  output logic [CNTW-1:0]   CycleCnt,
`endif
  output state_t            state_o
);

  localparam int WAITW = $clog2(MEM_TO + 1);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d, dec;
  strobe_t          strb_q, strb_d;
  logic [2:0]       mode_q, mode_d;
  logic [WAITW-1:0] wait_q, wait_d;
  logic             timeout;

  ctrl_decode #(.OPW(OPW)) u_decode (
    .instr_i (instr),
    .ctrl_o  (dec)
  );

  // Handshakes: Req is a level held by the host; Ack stays high in DONE until Req
  // drops. MemRead/MemWrite are held through MEM and a cycle with mem_ready=1
  // completes the access; on the timeout cycle mem_ready still wins.
  always_comb begin
    timeout = (state_q == ST_MEM) && (wait_q == WAITW'(MEM_TO)) && !mem_ready;
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Req) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = Halt ? ST_DONE : ST_EXEC;
      ST_EXEC: begin
        if (!ctrl_q.legal || ctrl_q.is_branch)   state_d = ST_FETCH;
        else if (ctrl_q.mem_rd || ctrl_q.mem_wr) state_d = ST_MEM;
        else                                     state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)    state_d = ctrl_q.mem_rd ? ST_WB : ST_FETCH;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_DONE:   if (!Req) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    ctrl_d = (state_q == ST_FETCH) ? dec : ctrl_q;
    wait_d = (state_q == ST_MEM && state_d == ST_MEM) ? wait_q + 1'b1 : '0;

    // Strobes are a function of the state being entered, so they are valid for its whole cycle.
    strb_d = '0;
    mode_d = '0;
    case (state_d)
      ST_FETCH: begin
        strb_d.ir_write = 1'b1;
        if (state_q == ST_MEM) begin
          strb_d.pc_write = 1'b1;
          strb_d.mem_err  = timeout;
        end
      end
      ST_EXEC: begin
        if (!ctrl_d.legal) begin
          strb_d.illegal_op = 1'b1;
          strb_d.pc_write   = 1'b1;
        end else if (ctrl_d.is_branch) begin
          strb_d.pc_write = 1'b1;
          strb_d.branch   = BrCond;
        end
      end
      ST_MEM: begin
        strb_d.mem_read  = ctrl_d.mem_rd;
        strb_d.mem_write = ctrl_d.mem_wr;
      end
      ST_WB: begin
        strb_d.reg_write  = ctrl_d.wb_en;
        strb_d.pc_write   = 1'b1;
        strb_d.mem_to_reg = ctrl_d.mem_to_reg;
      end
      ST_DONE:  strb_d.ack = Req;
      default:  ;
    endcase
    if (state_d inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB})
      mode_d = {ctrl_d.is_branch, ctrl_d.is_shift, ctrl_d.is_add};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ctrl_q  <= CTRL_NOP;
      strb_q  <= '0;
      mode_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      strb_q  <= strb_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
    end
  end

  assign IRWrite   = strb_q.ir_write;
  assign PCWrite   = strb_q.pc_write;
  assign Branch    = strb_q.branch;
  assign MemRead   = strb_q.mem_read;
  assign MemWrite  = strb_q.mem_write;
  assign MemtoReg  = strb_q.mem_to_reg;
  assign RegWrite  = strb_q.reg_write;
  assign Ack       = strb_q.ack;
  assign IllegalOp = strb_q.illegal_op;
  assign MemErr    = strb_q.mem_err;
  assign {isBranch, isShift, isAdd} = mode_q;
  assign ALUOp     = ALUOPW'(ctrl_q.alu_op);
  assign state_o   = state_q;

`ifdef CTRL_PERF_EN
  logic [CNTW-1:0] ret_q, cyc_q;

  // Counters hold their value in IDLE so software can read the last program's totals.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ret_q <= '0;
      cyc_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (Req) begin
        ret_q <= '0;
        cyc_q <= '0;
      end
    end else begin
      if (!(&cyc_q))                   cyc_q <= cyc_q + 1'b1;
      if (strb_q.pc_write && !(&ret_q)) ret_q <= ret_q + 1'b1;
    end
  end

  assign RetiredCnt = ret_q;
  assign CycleCnt   = cyc_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction stream, per-instruction
// scoreboard of retirement summaries, plus directed reset/halt/Ack checks.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int OPW    = 4;
  localparam int ALUOPW = 3;
  localparam int MEM_TO = 15;
  localparam int CNTW   = 16;
  localparam int W      = 27;
  localparam int NO_RDY = 999;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Req = 1'b0;
  logic [OPW-1:0]    instr = '0;
  logic              Halt = 1'b0;
  logic              BrCond = 1'b0;
  logic              mem_ready = 1'b0;
  logic              IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg, RegWrite;
  logic              isBranch, isShift, isAdd, Ack, IllegalOp, MemErr;
  logic [ALUOPW-1:0] ALUOp;
  state_t            state_o;
`ifdef CTRL_PERF_EN
  logic [CNTW-1:0]   RetiredCnt, CycleCnt;
`endif

  multicycle_ctrl #(.OPW(OPW), .ALUOPW(ALUOPW), .MEM_TO(MEM_TO), .CNTW(CNTW)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .instr(instr), .Halt(Halt), .BrCond(BrCond),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .isBranch(isBranch), .isShift(isShift), .isAdd(isAdd), .ALUOp(ALUOp), .Ack(Ack),
    .IllegalOp(IllegalOp), .MemErr(MemErr),
`ifdef CTRL_PERF_EN
    .RetiredCnt(RetiredCnt), .CycleCnt(CycleCnt),
`endif
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cur_w = NO_RDY;
  logic [W-1:0] exp_q[$];

  logic [12:0] all_strobes;
  assign all_strobes = {IRWrite, PCWrite, Branch, MemRead, MemWrite, MemtoReg, RegWrite,
                        isBranch, isShift, isAdd, Ack, IllegalOp, MemErr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-instruction summary: {ALUOp, Branch, RegWrite, MemtoReg, IllegalOp, MemErr,
  // decode-cycle mode, MemRead cycles, MemWrite cycles, IRWrite-to-PCWrite cycles}.
  function automatic logic [W-1:0] model(input int op, input bit brc, input int w, input bit to);
    bit         legal = (op < 8);
    bit         is_ld = legal && op == 4;
    bit         is_st = legal && op == 5;
    bit         is_br = legal && op == 3;
    int         mem_cycles = to ? MEM_TO + 1 : w + 1;
    int         lat;
    logic [2:0] alu = legal ? 3'(op) : 3'b111;
    logic [2:0] mode = legal ? {op == 3, op == 1, op == 0} : 3'b000;
    bit         regw = legal && !is_br && !is_st && !(is_ld && to);
    if (!legal || is_br)    lat = 3;
    else if (is_ld || is_st) lat = 4 + mem_cycles;
    else                    lat = 4;
    return {alu, is_br && brc, regw, is_ld && !to, !legal, (is_ld || is_st) && to, mode,
            5'(is_ld ? mem_cycles : 0), 5'(is_st ? mem_cycles : 0), 6'(lat)};
  endfunction

  // ---------------- memory responder ----------------
  int mem_cnt = 0;
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset && (MemRead || MemWrite)) begin
        mem_ready = (mem_cnt == cur_w);
        mem_cnt++;
      end else begin
        mem_ready = 1'b0;
        mem_cnt   = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit         active = 0;
  int         lat = 0, rd_cnt = 0, wr_cnt = 0;
  logic [2:0] mode_cap = '0;
  initial begin
    logic [W-1:0] act, exp;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        active = 0;
      end else begin
        if (active) begin
          lat++;
          rd_cnt += int'(MemRead);
          wr_cnt += int'(MemWrite);
          if (lat == 2) mode_cap = {isBranch, isShift, isAdd};
        end
        if (PCWrite) begin
          tests++;
          if (!active || exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pcwrite: got PCWrite=1 expected 0 at %0t", $time);
          end else begin
            act = {ALUOp, Branch, RegWrite, MemtoReg, IllegalOp, MemErr, mode_cap,
                   5'(rd_cnt), 5'(wr_cnt), 6'(lat)};
            exp = exp_q.pop_front();
            if (act !== exp) begin
              fails++;
              $display("FAIL retire_summary: got 0x%07h expected 0x%07h at %0t", act, exp, $time);
            end
          end
          active = 0;
        end
        if (Ack) active = 0;
        if (IRWrite) begin
          active = 1; lat = 1; rd_cnt = 0; wr_cnt = 0; mode_cap = '0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_irwrite();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!IRWrite && n < 200);
    if (!IRWrite) check("irwrite_timeout", 32'(IRWrite), 32'd1);
  endtask

  task automatic issue(input int op, input bit brc, input int w, input bit to);
    wait_irwrite();
    instr  = OPW'(op);
    BrCond = brc;
    Halt   = 1'b0;
    cur_w  = to ? NO_RDY : w;
    exp_q.push_back(model(op, brc, w, to));
  endtask

  task automatic issue_random();
    int op, r, w;
    bit to;
    op = ($urandom_range(0, 9) < 2) ? $urandom_range(8, 15) : $urandom_range(0, 7);
    r  = $urandom_range(0, 9);
    w  = (r < 5) ? r : MEM_TO;
    to = (r >= 8);
    issue(op, 1'($urandom_range(0, 1)), w, to);
  endtask

  task automatic halt_and_release();
    wait_irwrite();
    instr = OPW'($urandom_range(0, 7));
    Halt  = 1'b1;
    @(negedge Clk);
    check("ack_in_decode", 32'(Ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("ack_held", 32'(Ack), 32'd1);
      check("done_no_pcwrite", 32'(PCWrite), 32'd0);
    end
    check("state_done", 32'(state_o), 32'(ST_DONE));
    Req = 1'b0;
    @(negedge Clk);
    check("ack_falls", 32'(Ack), 32'd0);
    check("state_idle_after_done", 32'(state_o), 32'(ST_IDLE));
    Halt = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_strobes"}, 32'(all_strobes), 32'd0);
    check({tag, "_aluop"}, 32'(ALUOp), 32'd7);
    check({tag, "_state"}, 32'(state_o), 32'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (3) @(negedge Clk);
    check_reset_state("por");
    Reset = 1'b1;
    @(negedge Clk);
    check_reset_state("idle");

    Req = 1'b1;
    issue(0, 0, 0, 0);        // add
    issue(4, 0, 3, 0);        // load, three wait cycles
    issue(5, 0, 0, 1);        // store, memory never ready
    issue(3, 1, 0, 0);        // branch taken
    issue(3, 0, 0, 0);        // branch not taken
    issue(9, 0, 0, 0);        // illegal opcode
    issue(4, 0, MEM_TO, 0);   // ready on the timeout cycle
    issue(4, 0, 0, 1);        // load timeout
    for (int i = 0; i < 30; i++) issue_random();
    halt_and_release();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a stalled store
    Req = 1'b1;
    issue(5, 0, 0, 1);
    n = 0;
    while (!MemWrite && n < 50) begin @(negedge Clk); n++; end
    check("reached_mem", 32'(MemWrite), 32'd1);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    exp_q.delete();
    cur_w = NO_RDY;
    #1;
    check_reset_state("async_rst");
    @(negedge Clk);
    check_reset_state("rst_held");
    Reset = 1'b1;

    for (int i = 0; i < 8; i++) issue_random();
    halt_and_release();
    check("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
